piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//  Parametrised parallel-in serial-out shift register with valid/ready load handshake,
//  per-word shift direction, shift-enable gating and frame tracking (busy/last).
//  Sits between a word-wide producer and a bit-serial link (UART/SPI-style TX datapaths).
//  Supports back-to-back words with no idle bit between frames.
// PARAMETERS
//  WIDTH       8     data word width in bits; legal range >= 2
//  FILL_VALUE  1'b0  bit shifted into vacated positions; also the idle level of serial_out
// PORTS
//  clk           in   1      clock; all state updates on its rising edge
//  rst           in   1      asynchronous, active-high reset
//  data          in   WIDTH  parallel word to serialise
//  load_valid    in   1      producer offers data
//  load_ready    out  1      block accepts data this cycle
//  msb_first     in   1      direction for the word being loaded: 1 = MSB first, 0 = LSB first
//  shift_en      in   1      bit-rate strobe; advances one bit when high and serial_valid is high
//  serial_out    out  1      current serial bit
//  serial_valid  out  1      serial_out carries a frame bit
//  busy          out  1      a frame is in progress (equal to serial_valid)
//  last          out  1      serial_out carries the final bit of the frame
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, shift reg={WIDTH{FILL_VALUE}}, bit count=0, dir=0;
//    outputs: load_ready=1, serial_out=FILL_VALUE, serial_valid=0, busy=0, last=0.
//  - FSM: IDLE -> SHIFT on an accepted load; SHIFT -> IDLE after the last bit
//    is consumed with no new load; SHIFT -> SHIFT on a back-to-back load.
//  - Accept = load_valid & load_ready. load_ready = (state==IDLE) | (last & shift_en).
//  - On accept: register data and msb_first, count=0, state=SHIFT. First bit
//    (data[WIDTH-1] or data[0]) appears on serial_out the next cycle.
//  - In SHIFT: serial_out = reg[WIDTH-1] (msb) or reg[0] (lsb). On shift_en,
//    reg shifts toward the output end, FILL_VALUE enters the far end, count += 1.
//  - shift_en low in SHIFT: all state holds; serial_out is stable.
//  - last = SHIFT & (count == FRAME_LEN-1). FRAME_LEN = WIDTH (+1 with parity).
//  - The last bit is consumed on shift_en & last. A new load in the same cycle
//    wins: the new word is loaded with no gap. Otherwise state returns to IDLE and
//    serial_out returns to FILL_VALUE.
//  - load_valid in SHIFT before the last bit: not accepted (load_ready=0); the
//    producer holds data until it is accepted.
//  - msb_first and data are sampled only on accept; changes mid-frame are ignored.
//  - shift_en in IDLE has no effect.
//  - Count register width is $clog2(FRAME_LEN+1); it never wraps within a frame.
//  - rst asserted mid-frame: the frame is aborted immediately and all outputs
//    take their reset values asynchronously.
// CONFIGURATION
//  PISO_PARITY_EN defined: one even-parity bit (^data at load) is appended after the
//    WIDTH data bits. FRAME_LEN = WIDTH+1; last is asserted on the parity bit.
//  PISO_PARITY_EN undefined: no parity logic; FRAME_LEN = WIDTH.
// TESTING
//  1. WIDTH=8, load 8'hA5, msb_first=0, shift_en=1 held -> serial_out 1,0,1,0,0,1,0,1;
//     last is high on bit 8 only; idle afterwards with serial_out=0.
//  2. Load 8'hA5 with msb_first=1 -> serial_out 1,0,1,0,0,1,0,1 (MSB first);
//     then load 8'h01 with msb_first=1 -> 0,0,0,0,0,0,0,1.
//  3. Back-to-back: load_valid held with 8'hFF then 8'h00, shift_en=1 -> 16 contiguous bits,
//     load_ready pulses in the last-bit cycle, no idle gap.
//  4. shift_en toggling 1-of-3 cycles -> each bit is held exactly 3 cycles;
//     a load_valid pulse mid-frame is not accepted.
//  5. Assert rst after bit 3 of 8'hF0 -> same-cycle (async) serial_valid=0,
//     serial_out=FILL_VALUE, load_ready=1.
//  6. PISO_PARITY_EN, load 8'h07, msb_first=0 -> 9 bits, ninth bit=1; last is high
//     on bit 9; without the macro, last is high on bit 8.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with valid/ready load, per-word direction and frame tracking.
// Optional feature: define PISO_PARITY_EN to append one even-parity bit after the data bits.
module piso_serializer #(
  parameter int   WIDTH      = 8,
  parameter logic FILL_VALUE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             msb_first,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             last
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state;
  logic [FRAME_LEN-1:0] shreg;
  logic [CNT_W-1:0]     count;
  logic                 dir;
  logic                 accept;
  logic [FRAME_LEN-1:0] load_word;

  // The parity bit sits at the far end so it leaves after all data bits in either direction.
  always_comb begin
`ifdef PISO_PARITY_EN
    load_word = msb_first ? {data, ^data} : {^data, data};
`else
    load_word = data;
`endif
  end

  assign last         = (state == SHIFT) && (count == CNT_W'(FRAME_LEN - 1));
  assign load_ready   = (state == IDLE) | (last & shift_en);
  assign accept       = load_valid & load_ready;
  assign serial_valid = (state == SHIFT);
  assign busy         = serial_valid;
  assign serial_out   = serial_valid ? (dir ? shreg[FRAME_LEN-1] : shreg[0]) : FILL_VALUE;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= {FRAME_LEN{FILL_VALUE}};
      count <= '0;
      dir   <= 1'b0;
    end else if (accept) begin
      // A load in the last-bit cycle takes priority, giving back-to-back frames with no gap.
      state <= SHIFT;
      shreg <= load_word;
      count <= '0;
      dir   <= msb_first;
    end else if ((state == SHIFT) && shift_en) begin
      if (last) begin
        state <= IDLE;
        shreg <= {FRAME_LEN{FILL_VALUE}};
        count <= '0;
      end else begin
        shreg <= dir ? {shreg[FRAME_LEN-2:0], FILL_VALUE}
                     : {FILL_VALUE, shreg[FRAME_LEN-1:1]};
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule
